edge_sensing_multi: RTL and testbench

Parametrised multi-channel successor to the single-channel one-pulse edge former. Each channel does the following:
- synchronises an asynchronous input;
- rejects glitches shorter than a programmable number of stable cycles;
- detects rising, falling or both edges, selected per channel;
- emits a retriggerable pulse of PULSE_LEN clocks and sets a sticky pending flag, cleared by the consumer.

It sits between front-panel/trigger inputs and control FSMs and interrupt logic.

---
 rtl/edge_sensing_pkg.sv | 16 +
 rtl/edge_sensing_channel.sv | 89 ++++++++
 rtl/edge_sensing_multi.sv | 48 ++++
 tb/tb_edge_sensing_multi.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_sensing_pkg.sv
// Shared types and helpers for the multi-channel edge sensing block.
package edge_sensing_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Bits needed for a counter that holds values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/edge_sensing_channel.sv
// One channel: synchroniser, glitch filter, edge qualifier, pulse stretcher
// and sticky pending flag.
module edge_sensing_channel
  import edge_sensing_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int PULSE_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  edge_mode_t mode,
  input  logic       clear,
  output logic       q,
  output logic       level,
  output logic       pending,
  output logic       pending_next
);

  localparam int FW = cnt_width(FILTER_LEN);
  localparam int PW = cnt_width(PULSE_LEN);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [FW-1:0]          filt_cnt, filt_cnt_next;
  logic                   level_next;
  logic                   rise, fall, event_hit;
  logic [PW-1:0]          pulse_cnt, pulse_cnt_next;

  assign s = sync[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    filt_cnt_next = '0;
    level_next    = level;
    if (s != level) begin
      if (filt_cnt == FILT_LAST) level_next = s;
      else                       filt_cnt_next = filt_cnt + 1'b1;
    end
  end

  assign rise = level_next & ~level;
  assign fall = ~level_next & level;

  always_comb begin
    event_hit = 1'b0;
    case (mode)
      EDGE_OFF:  event_hit = 1'b0;
      EDGE_RISE: event_hit = rise;
      EDGE_FALL: event_hit = fall;
      EDGE_BOTH: event_hit = rise | fall;
    endcase
  end

  // A new event reloads the counter, so a retrigger extends the pulse gaplessly.
  always_comb begin
    pulse_cnt_next = '0;
    if (event_hit)              pulse_cnt_next = PULSE_LOAD;
    else if (pulse_cnt != '0)   pulse_cnt_next = pulse_cnt - 1'b1;
  end

  // Set beats clear when both land in the same cycle.
  assign pending_next = event_hit | (pending & ~clear);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      filt_cnt  <= '0;
      level     <= 1'b0;
      pulse_cnt <= '0;
      q         <= 1'b0;
      pending   <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], d};
      filt_cnt  <= filt_cnt_next;
      level     <= level_next;
      pulse_cnt <= pulse_cnt_next;
      q         <= (pulse_cnt_next != '0);
      pending   <= pending_next;
    end
  end

endmodule

// File: rtl/edge_sensing_multi.sv
// Multi-channel edge sensing: independent channels plus a registered
// any_pending summary aligned with the pending flags.
module edge_sensing_multi
  import edge_sensing_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int PULSE_LEN   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      d,
  input  logic [CHANNELS-1:0][1:0] mode,
  input  logic [CHANNELS-1:0]      clear,
  output logic [CHANNELS-1:0]      q,
  output logic [CHANNELS-1:0]      level,
  output logic [CHANNELS-1:0]      pending,
  output logic                     any_pending
);

  logic [CHANNELS-1:0] pending_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_sensing_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .PULSE_LEN   (PULSE_LEN)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .d            (d[i]),
      .mode         (edge_mode_t'(mode[i])),
      .clear        (clear[i]),
      .q            (q[i]),
      .level        (level[i]),
      .pending      (pending[i]),
      .pending_next (pending_next[i])
    );
  end

  // Reduce the next-state flags so any_pending lands on the same edge as pending.
  always_ff @(posedge clk) begin
    if (rst) any_pending <= 1'b0;
    else     any_pending <= |pending_next;
  end

endmodule

// File: tb/tb_edge_sensing_multi.sv
// Self-checking bench: two configurations share stimulus and are compared
// every cycle against a window-based behavioural model.
module tb_edge_sensing_multi;
  import edge_sensing_pkg::*;

  localparam int S  = 2;
  localparam int NA = 8, FA = 4, PA = 1;
  localparam int NB = 4, FB = 1, PB = 6;
  localparam int HL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [7:0]      d, clear;
  logic [7:0][1:0] mode;
  logic [7:0]      q_a, level_a, pending_a;
  logic            any_a;
  logic [3:0]      q_b, level_b, pending_b;
  logic            any_b;

  wire [24:0] obs_a = {q_a, level_a, pending_a, any_a};
  wire [12:0] obs_b = {q_b, level_b, pending_b, any_b};

  edge_sensing_multi #(.CHANNELS(NA), .SYNC_STAGES(S), .FILTER_LEN(FA), .PULSE_LEN(PA)) dut_a (
    .clk(clk), .rst(rst), .d(d), .mode(mode), .clear(clear),
    .q(q_a), .level(level_a), .pending(pending_a), .any_pending(any_a));

  edge_sensing_multi #(.CHANNELS(NB), .SYNC_STAGES(S), .FILTER_LEN(FB), .PULSE_LEN(PB)) dut_b (
    .clk(clk), .rst(rst), .d(d[3:0]), .mode(mode[3:0]), .clear(clear[3:0]),
    .q(q_b), .level(level_b), .pending(pending_b), .any_pending(any_b));

  // Model: level flips once the last FILTER_LEN synchronised samples all
  // disagree with it; q is high while fewer than PULSE_LEN edges have passed
  // since the latest qualified event.
  bit         hist   [2][8][HL];
  bit         m_lv   [2][8];
  bit         m_pend [2][8];
  int         last_ev[2][8];
  int         edge_n;
  logic [24:0] exp_a;
  logic [12:0] exp_b;
  int checks, passes;

  task automatic model_step(input int inst, input int nch, input int flen);
    bit flip, ev;
    for (int c = 0; c < nch; c++) begin
      if (rst) begin
        for (int j = 0; j < HL; j++) hist[inst][c][j] = 1'b0;
        m_lv[inst][c] = 1'b0; m_pend[inst][c] = 1'b0; last_ev[inst][c] = -1000;
      end else begin
        for (int j = HL - 1; j > 0; j--) hist[inst][c][j] = hist[inst][c][j-1];
        hist[inst][c][0] = d[c];
        flip = 1'b1;
        for (int k = 0; k < flen; k++) if (hist[inst][c][S+k] == m_lv[inst][c]) flip = 1'b0;
        ev = 1'b0;
        if (flip) begin
          ev = m_lv[inst][c] ? mode[c][1] : mode[c][0];
          m_lv[inst][c] = !m_lv[inst][c];
        end
        if (ev) last_ev[inst][c] = edge_n;
        if (ev) m_pend[inst][c] = 1'b1;
        else if (clear[c]) m_pend[inst][c] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [7:0] qa, la, pa;
    logic [3:0] qb, lb, pb;
    edge_n++;
    model_step(0, NA, FA);
    model_step(1, NB, FB);
    for (int c = 0; c < NA; c++) begin
      qa[c] = (edge_n - last_ev[0][c]) < PA; la[c] = m_lv[0][c]; pa[c] = m_pend[0][c];
    end
    for (int c = 0; c < NB; c++) begin
      qb[c] = (edge_n - last_ev[1][c]) < PB; lb[c] = m_lv[1][c]; pb[c] = m_pend[1][c];
    end
    exp_a = {qa, la, pa, |pa};
    exp_b = {qb, lb, pb, |pb};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d = 8'($urandom); mode = '0; clear = '0;
    repeat (3) begin
      tick();
      checks++; if (obs_a !== exp_a) $display("FAIL reset_model_a: got %h expected %h", obs_a, exp_a); else passes++;
    end
    checks++;
    if ({obs_a, obs_b} !== 38'd0) $display("FAIL reset_zero: got %h expected 0", {obs_a, obs_b});
    else passes++;
    rst = 1'b0; d = '0;
    repeat (8) begin
      tick();
      checks++; if (obs_b !== exp_b) $display("FAIL reset_model_b: got %h expected %h", obs_b, exp_b); else passes++;
    end
  endtask

  task automatic test_basic_rise();
    int first_a, first_b, hi_a;
    mode = '0; mode[0] = EDGE_RISE; d = '0; clear = '1;
    tick(); clear = '0;
    repeat (8) tick();
    d[0] = 1'b1; first_a = -1; first_b = -1; hi_a = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (obs_a !== exp_a) $display("FAIL rise_model_a: got %h expected %h", obs_a, exp_a); else passes++;
      checks++; if (obs_b !== exp_b) $display("FAIL rise_model_b: got %h expected %h", obs_b, exp_b); else passes++;
      if (q_a[0]) begin hi_a++; if (first_a < 0) first_a = i; end
      if (q_b[0] && first_b < 0) first_b = i;
    end
    checks++; if (first_a != S + FA - 1) $display("FAIL rise_latency_a: got %0d expected %0d", first_a, S + FA - 1); else passes++;
    checks++; if (first_b != S + FB - 1) $display("FAIL rise_latency_b: got %0d expected %0d", first_b, S + FB - 1); else passes++;
    checks++; if (hi_a != 1) $display("FAIL rise_width: got %0d expected 1", hi_a); else passes++;
    checks++; if ({level_a[0], pending_a[0], any_a} !== 3'b111) $display("FAIL rise_flags: got %b expected 111", {level_a[0], pending_a[0], any_a}); else passes++;
    d[0] = 1'b0; hi_a = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (obs_a !== exp_a) $display("FAIL fall_model_a: got %h expected %h", obs_a, exp_a); else passes++;
      if (q_a[0]) hi_a++;
    end
    checks++; if (hi_a != 0 || level_a[0] !== 1'b0) $display("FAIL fall_ignored: got q %0d level %b expected 0 0", hi_a, level_a[0]); else passes++;
  endtask

  task automatic test_glitch();
    int seen, hi, seen_lv;
    clear = '1; tick(); clear = '0;
    d[0] = 1'b1; seen = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) d[0] = 1'b0;
      tick();
      checks++; if (obs_a !== exp_a) $display("FAIL glitch_model_a: got %h expected %h", obs_a, exp_a); else passes++;
      if (q_a[0] || level_a[0] || pending_a[0]) seen++;
    end
    checks++; if (seen != 0) $display("FAIL glitch_reject: got %0d active cycles expected 0", seen); else passes++;
    d[0] = 1'b1; hi = 0; seen_lv = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) d[0] = 1'b0;
      tick();
      checks++; if (obs_a !== exp_a) $display("FAIL accept_model_a: got %h expected %h", obs_a, exp_a); else passes++;
      if (q_a[0]) hi++;
      if (level_a[0]) seen_lv = 1;
    end
    checks++; if (hi != 1 || seen_lv != 1) $display("FAIL glitch_accept: got pulses %0d level %0d expected 1 1", hi, seen_lv); else passes++;
  endtask

  task automatic test_modes();
    int cnt[4];
    mode = '0; mode[0] = EDGE_RISE; mode[1] = EDGE_FALL; mode[2] = EDGE_BOTH; mode[3] = EDGE_OFF;
    d = '0; repeat (10) tick();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int i = 0; i < 70; i++) begin
      if (i < 60) d[3:0] = ((i / 10) % 2 == 0) ? 4'hF : 4'h0;
      else        d[3:0] = 4'h0;
      tick();
      checks++; if (obs_a !== exp_a) $display("FAIL modes_model_a: got %h expected %h", obs_a, exp_a); else passes++;
      checks++; if (obs_b !== exp_b) $display("FAIL modes_model_b: got %h expected %h", obs_b, exp_b); else passes++;
      checks++;
      if (level_a[1] !== level_a[2] || level_a[2] !== level_a[3] || level_a[3] !== level_a[0])
        $display("FAIL modes_level: got %b expected all equal", level_a[3:0]);
      else passes++;
      for (int c = 0; c < 4; c++) if (q_a[c]) cnt[c]++;
    end
    checks++;
    if (cnt[0] != 3 || cnt[1] != 3 || cnt[2] != 6 || cnt[3] != 0)
      $display("FAIL modes_counts: got %0d %0d %0d %0d expected 3 3 6 0", cnt[0], cnt[1], cnt[2], cnt[3]);
    else passes++;
  endtask

  task automatic test_retrigger();
    int run, best, runs;
    mode[2] = EDGE_BOTH; d = '0; repeat (6) tick();
    run = 0; best = 0; runs = 0;
    for (int i = 0; i < 24; i++) begin
      d[2] = (i < 3);
      tick();
      checks++; if (obs_b !== exp_b) $display("FAIL retrig_model_b: got %h expected %h", obs_b, exp_b); else passes++;
      if (q_b[2]) begin if (run == 0) runs++; run++; if (run > best) best = run; end
      else run = 0;
    end
    checks++; if (best != 9 || runs != 1) $display("FAIL retrig_run: got %0d cycles in %0d runs expected 9 in 1", best, runs); else passes++;
  endtask

  task automatic test_pending_race();
    mode = '0; mode[0] = EDGE_RISE; d = '0; clear = '1;
    tick(); clear = '0;
    repeat (9) tick();
    d[0] = 1'b1;
    repeat (S + FA - 1) tick();
    clear[0] = 1'b1;
    tick();
    checks++; if (obs_a !== exp_a) $display("FAIL race_model_a: got %h expected %h", obs_a, exp_a); else passes++;
    checks++; if ({q_a[0], pending_a[0]} !== 2'b11) $display("FAIL race_set_wins: got %b expected 11", {q_a[0], pending_a[0]}); else passes++;
    tick();
    checks++; if ({pending_a[0], any_a} !== 2'b00) $display("FAIL race_clear: got %b expected 00", {pending_a[0], any_a}); else passes++;
    checks++; if (obs_b !== exp_b) $display("FAIL race_model_b: got %h expected %h", obs_b, exp_b); else passes++;
    clear = '0; d[0] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    int first_a, first_b;
    mode = '0; mode[0] = EDGE_RISE; d = '0; clear = '1;
    tick(); clear = '0;
    repeat (8) tick();
    d[0] = 1'b1;
    repeat (S + FB) tick();
    checks++; if (q_b[0] !== 1'b1) $display("FAIL mid_pulse_on: got %b expected 1", q_b[0]); else passes++;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (obs_b !== 13'd0) $display("FAIL mid_reset_b: got %h expected 0", obs_b); else passes++;
    rst = 1'b0; first_a = -1; first_b = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (obs_b !== exp_b) $display("FAIL mid_model_b: got %h expected %h", obs_b, exp_b); else passes++;
      if (q_a[0] && first_a < 0) first_a = i;
      if (q_b[0] && first_b < 0) first_b = i;
    end
    checks++;
    if (first_a != S + FA - 1 || first_b != S + FB - 1)
      $display("FAIL mid_fresh_rise: got %0d %0d expected %0d %0d", first_a, first_b, S + FA - 1, S + FB - 1);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
      if ($urandom_range(0, 63) == 0) mode = 16'($urandom);
      clear = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rst   = ($urandom_range(0, 399) == 0);
      tick();
      checks++; if (obs_a !== exp_a) $display("FAIL random_a @%0d: got %h expected %h", i, obs_a, exp_a); else passes++;
      checks++; if (obs_b !== exp_b) $display("FAIL random_b @%0d: got %h expected %h", i, obs_b, exp_b); else passes++;
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0; edge_n = 0;
    rst = 1'b1; d = '0; mode = '0; clear = '0;
    for (int i = 0; i < 2; i++) for (int c = 0; c < 8; c++) last_ev[i][c] = -1000;
    test_reset();
    test_basic_rise();
    test_glitch();
    test_modes();
    test_retrigger();
    test_pending_race();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
